// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl: ALU operand forwarding selects, EX/MEM/WB destination scoreboard and load-use stall control.
// Define FWD_WB_EN to forward WB results (select 11); otherwise a MEM-stage producer costs one bubble.
module operand_fwd_ctrl #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic [1:0]            mux_lines_A,
    output logic [1:0]            mux_lines_B,
    output logic                  stall
);
    localparam int CW = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;

    typedef enum logic {RUN, STALL} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic                  ex_w, ex_ld, mem_w;
    logic [REG_ADDR_W-1:0] ex_rd, mem_rd;
    logic                  ex_a, ex_b, mem_a, mem_b, hazard;
    logic [1:0]            sel_a, sel_b;

    // WB-stage producers are not tracked: the regfile writes through, so they select 00.
    assign ex_a  = id_uses_rs & ex_w & (ex_rd == id_rs);
    assign ex_b  = id_uses_rt & ex_w & (ex_rd == id_rt);
    assign mem_a = id_uses_rs & mem_w & (mem_rd == id_rs);
    assign mem_b = id_uses_rt & mem_w & (mem_rd == id_rt);

`ifdef FWD_WB_EN
    assign hazard = id_valid & ex_ld & (ex_a | ex_b);
    assign sel_a  = ex_a ? 2'b10 : mem_a ? 2'b11 : 2'b00;
    assign sel_b  = ex_b ? 2'b10 : mem_b ? 2'b11 : 2'b00;
`else
    assign hazard = id_valid & ((ex_ld & (ex_a | ex_b)) | mem_a | mem_b);
    assign sel_a  = ex_a ? 2'b10 : 2'b00;
    assign sel_b  = ex_b ? 2'b10 : 2'b00;
`endif

    assign id_ready = (state == RUN) & ~hazard & ex_ready & ~flush;
    assign stall    = id_valid & ~id_ready & ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            count       <= '0;
            ex_valid    <= 1'b0;
            ex_w        <= 1'b0;
            ex_ld       <= 1'b0;
            ex_rd       <= '0;
            mem_w       <= 1'b0;
            mem_rd      <= '0;
            mux_lines_A <= 2'b00;
            mux_lines_B <= 2'b00;
        end else if (ex_ready) begin
            mem_w       <= ex_w;
            mem_rd      <= ex_rd;
            ex_valid    <= id_ready;
            ex_w        <= id_ready & id_reg_write & (id_rd != '0);
            ex_ld       <= id_ready & id_is_load;
            ex_rd       <= id_rd;
            mux_lines_A <= id_ready ? sel_a : 2'b00;
            mux_lines_B <= id_ready ? sel_b : 2'b00;
            if (flush) begin
                state <= RUN;
                count <= '0;
            end else if (state == STALL) begin
                count <= count - 1'b1;
                if (count == CW'(1)) state <= RUN;
            end else if (hazard && LOAD_STALL_CYCLES > 1) begin
                state <= STALL;
                count <= CW'(LOAD_STALL_CYCLES - 1);
            end
        end
    end
endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// tb_operand_fwd_ctrl: random issue stream into two instances (1 and 3 load-stall cycles),
// checked against a slot-history reference model through an EX-output scoreboard.
module tb_operand_fwd_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_load, ex_ready, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       rdy[2], stl[2], exv[2];
    logic [1:0] ma[2], mb[2];

    int checks = 0;
    int errors = 0;

`ifdef FWD_WB_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    typedef struct packed {logic w; logic ld; logic [4:0] rd;} ent_t;
    typedef struct packed {logic v; logic [1:0] a; logic [1:0] b;} out_t;

    ent_t h_ex[2], h_mem[2];
    int   blk[2];
    out_t q0[$], q1[$];
    bit   did_rst = 1'b0;

    operand_fwd_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(rdy[0]),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_ready(ex_ready), .flush(flush), .ex_valid(exv[0]),
        .mux_lines_A(ma[0]), .mux_lines_B(mb[0]), .stall(stl[0]));

    operand_fwd_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(rdy[1]),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_ready(ex_ready), .flush(flush), .ex_valid(exv[1]),
        .mux_lines_A(ma[1]), .mux_lines_B(mb[1]), .stall(stl[1]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    // {hazard, select} for one operand, from which producer slot holds its source register
    function automatic logic [2:0] dep(input int k, input logic [4:0] src, input logic use_src);
        logic e, m, hz;
        logic [1:0] sel;
        e   = use_src && h_ex[k].w && h_ex[k].rd == src;
        m   = use_src && h_mem[k].w && h_mem[k].rd == src;
        hz  = (e && h_ex[k].ld) || (!WB && m);
        sel = e ? 2'b10 : (WB && m) ? 2'b11 : 2'b00;
        return {hz, sel};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            h_ex[k]  = '0;
            h_mem[k] = '0;
            blk[k]   = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("reset_ex_valid", k, {7'd0, exv[k]}, 8'd0);
            chk("reset_mux_A", k, {6'd0, ma[k]}, 8'd0);
            chk("reset_mux_B", k, {6'd0, mb[k]}, 8'd0);
        end
    endtask

    task automatic step_model();
        logic [2:0] da, db;
        logic hz, r;
        ent_t e;
        out_t o;
        int lsc;
        for (int k = 0; k < 2; k++) begin
            lsc = (k == 0) ? 1 : 3;
            da  = dep(k, id_rs, id_uses_rs);
            db  = dep(k, id_rt, id_uses_rt);
            hz  = id_valid && (da[2] || db[2]);
            r   = blk[k] == 0 && !hz && ex_ready && !flush;
            chk("id_ready", k, {7'd0, rdy[k]}, {7'd0, r});
            chk("stall", k, {7'd0, stl[k]}, {7'd0, id_valid && !r && ex_ready});
            if (ex_ready) begin
                o = r ? {1'b1, da[1:0], db[1:0]} : '0;
                e = r ? {id_reg_write && id_rd != 0, id_is_load, id_rd} : '0;
                if (k == 0) q0.push_back(o);
                else q1.push_back(o);
                h_mem[k] = h_ex[k];
                h_ex[k]  = e;
                if (flush) blk[k] = 0;
                else if (blk[k] > 0) blk[k]--;
                else if (hz) blk[k] = lsc - 1;
            end
        end
    endtask

    // Monitor: every advance puts a new instruction or bubble into EX
    always @(posedge clk) begin
        bit adv;
        out_t exp_o;
        adv = ex_ready && rst_n;
        #1;
        if (adv) begin
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    chk("scoreboard_empty", k, 8'd1, 8'd0);
                end else begin
                    exp_o = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk("ex_valid", k, {7'd0, exv[k]}, {7'd0, exp_o.v});
                    chk("mux_A", k, {6'd0, ma[k]}, {6'd0, exp_o.a});
                    chk("mux_B", k, {6'd0, mb[k]}, {6'd0, exp_o.b});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_load, ex_ready, flush} = '0;
        {id_rs, id_rt, id_rd} = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!did_rst && cyc > 300 && blk[1] > 0) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                model_reset();
                did_rst = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
            end
            id_valid     = $urandom_range(0, 9) < 8;
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_rd        = 5'($urandom_range(0, 3));
            id_uses_rs   = $urandom_range(0, 3) != 0;
            id_uses_rt   = $urandom_range(0, 3) != 0;
            id_reg_write = $urandom_range(0, 9) < 8;
            id_is_load   = $urandom_range(0, 9) < 3;
            ex_ready     = cyc < 100 ? 1'b1 : $urandom_range(0, 9) < 8;
            flush        = cyc >= 100 && $urandom_range(0, 19) == 0;
            #1;
            step_model();
        end
        @(negedge clk);
        ex_ready = 1'b0;
        @(negedge clk);
        chk("reset_during_stall_seen", 0, {7'd0, did_rst}, 8'd1);
        chk("scoreboard_drained", 0, 8'(q0.size()), 8'd0);
        chk("scoreboard_drained", 1, 8'(q1.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
